// File: rtl/rst_seq_arty7_if.sv
// rst_seq_arty7_if
// Groups the reset sequencer's board-side inputs, reset outputs and debug
// state into one bundle.
//
// Signals:
//   mmcmLocked_i  MMCM LOCKED, asynchronous to the sequencer clock
//   btnRstn_i     board reset button, active low, asynchronous, bouncy
//   swRstReq_i    single-cycle software/watchdog reset request, synchronous
//   periphRstn_o  active-low peripheral reset
//   cpuRstn_o     active-low CPU reset
//   seqDone_o     high while the sequencer sits in RUN
//   rstCause_o    sticky reset cause: bit0 lock loss, bit1 button, bit2 software
//   dbgState_o    current FSM state (0 HOLD, 1 PERIPH, 2 CPU, 3 RUN, 4 SWRST)
//
// Handshake: there is no valid/ready pair here. Every input is a level,
// except swRstReq_i, which is a one-cycle pulse sampled on a rising clock
// edge. Every output is a registered level.
//
// Modports:
//   master  drives the inputs and observes the outputs (board / testbench)
//   slave   the sequencer itself
interface rst_seq_arty7_if;
  logic       mmcmLocked_i;
  logic       btnRstn_i;
  logic       swRstReq_i;
  logic       periphRstn_o;
  logic       cpuRstn_o;
  logic       seqDone_o;
  logic [2:0] rstCause_o;
  logic [2:0] dbgState_o;

  modport master (
    output mmcmLocked_i, btnRstn_i, swRstReq_i,
    input  periphRstn_o, cpuRstn_o, seqDone_o, rstCause_o, dbgState_o
  );

  modport slave (
    input  mmcmLocked_i, btnRstn_i, swRstReq_i,
    output periphRstn_o, cpuRstn_o, seqDone_o, rstCause_o, dbgState_o
  );
endinterface

// File: rtl/rst_seq_arty7.sv
// rst_seq_arty7
// Reset sequencer placed after the Arty-7 MMCM.
// - Qualifies LOCKED: it must stay high for LOCK_STABLE_CYC cycles.
// - Debounces the board button.
// - Accepts a software/watchdog reset pulse.
// - Releases the peripheral reset first, then the CPU reset.
//
// Ports:
//   clk_i   20 MHz system clock from the MMCM
//   rstn_i  asynchronous active-low reset (power-on / MMCM RST domain)
//   bus     rst_seq_arty7_if.slave: board inputs, reset outputs, cause, debug state
//
// Build option:
//   RST_SEQ_CAUSE_EN  When defined, rstCause_o records sticky reset causes.
//                     When undefined, rstCause_o is tied to 3'b000 and the
//                     cause flops are not built.
module rst_seq_arty7 #(
  parameter int LOCK_STABLE_CYC = 256,
  parameter int DEBOUNCE_CYC    = 20000,
  parameter int PERIPH_HOLD_CYC = 16,
  parameter int CPU_HOLD_CYC    = 16,
  parameter int SW_RST_CYC      = 32
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  rst_seq_arty7_if.slave  bus
);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_PERIPH = 3'd1,
    S_CPU    = 3'd2,
    S_RUN    = 3'd3,
    S_SWRST  = 3'd4
  } state_t;

  localparam int SEQ_MAXP_A = (PERIPH_HOLD_CYC > CPU_HOLD_CYC) ? PERIPH_HOLD_CYC : CPU_HOLD_CYC;
  localparam int SEQ_MAXP   = (SEQ_MAXP_A > SW_RST_CYC) ? SEQ_MAXP_A : SW_RST_CYC;
  localparam int LW = $clog2(LOCK_STABLE_CYC + 1);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int SW = $clog2(SEQ_MAXP + 1);

  localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_STABLE_CYC - 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYC - 1);
  localparam logic [SW-1:0] PERIPH_LAST = SW'(PERIPH_HOLD_CYC - 1);
  localparam logic [SW-1:0] CPU_LAST    = SW'(CPU_HOLD_CYC - 1);
  localparam logic [SW-1:0] SWRST_LAST  = SW'(SW_RST_CYC - 1);

  // Synchronisers and the button debouncer.
  logic          lock_s1, lock_s2;
  logic          btn_s1, btn_s2;
  logic          btn_acc;
  logic [DW-1:0] deb_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
      btn_s1  <= 1'b1;
      btn_s2  <= 1'b1;
      btn_acc <= 1'b1;
      deb_cnt <= '0;
    end else begin
      lock_s1 <= bus.mmcmLocked_i;
      lock_s2 <= lock_s1;
      btn_s1  <= bus.btnRstn_i;
      btn_s2  <= btn_s1;
      // The counter measures how long the synchronised button has stayed
      // away from the accepted level. Any return to the accepted level
      // restarts it, so bounces shorter than DEBOUNCE_CYC never get through.
      if (btn_s2 == btn_acc) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        btn_acc <= btn_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  logic locked;
  logic btn_fall;
  assign locked   = lock_s2;
  // The accepted level drops on this same edge, so btn_fall is one cycle wide.
  assign btn_fall = btn_acc && !btn_s2 && (deb_cnt == DEB_LAST);

  // Sequencing FSM.
  state_t        state, state_n;
  logic [LW-1:0] lock_cnt, lock_cnt_n;
  logic [SW-1:0] seq_cnt, seq_cnt_n;
  logic          periph_q, periph_n;
  logic          cpu_q, cpu_n;
  logic          done_q, done_n;

  logic lock_evt, btn_evt, sw_evt;
  assign lock_evt = (state != S_HOLD) && !locked;
  assign btn_evt  = (state != S_HOLD) && btn_fall;
  assign sw_evt   = bus.swRstReq_i &&
                    ((state == S_PERIPH) || (state == S_CPU) || (state == S_RUN));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= S_HOLD;
      lock_cnt <= '0;
      seq_cnt  <= '0;
      periph_q <= 1'b0;
      cpu_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      lock_cnt <= lock_cnt_n;
      seq_cnt  <= seq_cnt_n;
      periph_q <= periph_n;
      cpu_q    <= cpu_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    lock_cnt_n = lock_cnt;
    seq_cnt_n  = seq_cnt;
    periph_n   = periph_q;
    cpu_n      = cpu_q;
    // Priority: lock loss, then button, then software request.
    if (lock_evt || btn_evt) begin
      state_n    = S_HOLD;
      lock_cnt_n = '0;
      seq_cnt_n  = '0;
      periph_n   = 1'b0;
      cpu_n      = 1'b0;
    end else if (sw_evt) begin
      state_n    = S_SWRST;
      lock_cnt_n = '0;
      seq_cnt_n  = '0;
      periph_n   = 1'b0;
      cpu_n      = 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          periph_n  = 1'b0;
          cpu_n     = 1'b0;
          seq_cnt_n = '0;
          if (!locked) begin
            lock_cnt_n = '0;
          end else if (lock_cnt == LOCK_LAST) begin
            state_n    = S_PERIPH;
            lock_cnt_n = '0;
          end else begin
            lock_cnt_n = lock_cnt + LW'(1);
          end
        end
        S_PERIPH: begin
          if (seq_cnt == PERIPH_LAST) begin
            state_n   = S_CPU;
            periph_n  = 1'b1;
            seq_cnt_n = '0;
          end else begin
            seq_cnt_n = seq_cnt + SW'(1);
          end
        end
        S_CPU: begin
          // The CPU is released only from here, after periph_q has been
          // set, so the CPU never runs while the peripherals are in reset.
          if (seq_cnt == CPU_LAST) begin
            state_n   = S_RUN;
            cpu_n     = 1'b1;
            seq_cnt_n = '0;
          end else begin
            seq_cnt_n = seq_cnt + SW'(1);
          end
        end
        S_RUN: begin
        end
        S_SWRST: begin
          periph_n = 1'b0;
          cpu_n    = 1'b0;
          if (seq_cnt == SWRST_LAST) begin
            state_n   = S_PERIPH;
            seq_cnt_n = '0;
          end else begin
            seq_cnt_n = seq_cnt + SW'(1);
          end
        end
        default: begin
          state_n    = S_HOLD;
          lock_cnt_n = '0;
          seq_cnt_n  = '0;
          periph_n   = 1'b0;
          cpu_n      = 1'b0;
        end
      endcase
    end
    done_n = (state_n == S_RUN);
  end

  assign bus.periphRstn_o = periph_q;
  assign bus.cpuRstn_o    = cpu_q;
  assign bus.seqDone_o    = done_q;
  assign bus.dbgState_o   = state;

`ifdef RST_SEQ_CAUSE_EN
  logic [2:0] cause_q;
  logic [2:0] cause_set;

  // Causes that fire in the same cycle are all recorded, whatever the
  // FSM priority between them.
  always_comb begin
    cause_set = {sw_evt, btn_evt, lock_evt};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cause_q <= 3'b000;
    end else begin
      cause_q <= cause_q | cause_set;
    end
  end

  assign bus.rstCause_o = cause_q;
`else
  assign bus.rstCause_o = 3'b000;
`endif

endmodule
